// File: rtl/pe_inject_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_inject_queue : first-word-fall-through injection FIFO from a PE to its
//                   router port, with head-wait starvation and PE-stall stats.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pe_inject_queue #(
  parameter int X_W       = 2,
  parameter int Y_W       = 2,
  parameter int D_W       = 32,
  parameter int DEPTH     = 4,
  parameter int STARVE_TH = 8,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [X_W-1:0]           pe_x,
  input  logic [Y_W-1:0]           pe_y,
  input  logic [D_W-1:0]           pe_d,
  input  logic                     pe_v,
  output logic                     pe_rdy,
  output logic [X_W-1:0]           i_x,
  output logic [Y_W-1:0]           i_y,
  output logic [D_W-1:0]           i_d,
  output logic                     i_v,
  input  logic                     i_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     starve,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_OCC_W  = c_PTR_W + 1;
  localparam int c_WAIT_W = $clog2(STARVE_TH + 1);
  localparam int c_E_W    = X_W + Y_W + D_W;
  localparam logic [c_OCC_W-1:0]  c_FULL = c_OCC_W'(DEPTH);
  localparam logic [c_WAIT_W-1:0] c_TH   = c_WAIT_W'(STARVE_TH);

  logic [c_E_W-1:0]    mem_q [DEPTH];
  logic [c_PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [c_OCC_W-1:0]  count_q, count_d;
  logic [c_WAIT_W-1:0] wait_q, wait_d;
  logic                starve_q, starve_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                w_push, w_pop;
  logic [c_E_W-1:0]    w_head;

  // Ready and valid come straight from registered occupancy: no ack-to-ready path.
  assign pe_rdy = (count_q != c_FULL);
  assign i_v    = (count_q != '0);
  assign w_push = pe_v && pe_rdy;
  assign w_pop  = i_v && i_ack;
  assign w_head = i_v ? mem_q[head_q] : '0;

  assign {i_x, i_y, i_d} = w_head;
  assign count     = count_q;
  assign starve    = starve_q;
  assign stall_cnt = stall_q;

  always_comb begin
    head_d   = head_q + c_PTR_W'(w_pop);
    tail_d   = tail_q + c_PTR_W'(w_push);
    count_d  = count_q;
    wait_d   = wait_q;
    stall_d  = stall_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_OCC_W'(1);
      2'b01:   count_d = count_q - c_OCC_W'(1);
      default: count_d = count_q;
    endcase
    if (w_pop || !i_v) begin
      wait_d = '0;
    end else if (wait_q != c_TH) begin
      wait_d = wait_q + c_WAIT_W'(1);
    end
    starve_d = (wait_d == c_TH);
    if (pe_v && !pe_rdy && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      starve_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // Storage needs no reset; the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      mem_q[tail_q] <= {pe_x, pe_y, pe_d};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_inject_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pe_inject_queue : directed plus randomized stimulus against a queue model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pe_inject_queue;

  localparam int X_W       = 2;
  localparam int Y_W       = 2;
  localparam int D_W       = 32;
  localparam int DEPTH     = 4;
  localparam int STARVE_TH = 8;
  localparam int CNT_W     = 16;
  localparam int c_E_W     = X_W + Y_W + D_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [X_W-1:0]         pe_x;
  logic [Y_W-1:0]         pe_y;
  logic [D_W-1:0]         pe_d;
  logic                   pe_v;
  logic                   pe_rdy;
  logic [X_W-1:0]         i_x;
  logic [Y_W-1:0]         i_y;
  logic [D_W-1:0]         i_d;
  logic                   i_v;
  logic                   i_ack;
  logic [$clog2(DEPTH):0] count;
  logic                   starve;
  logic [CNT_W-1:0]       stall_cnt;

  always #5 clk = ~clk;

  pe_inject_queue #(
    .X_W(X_W), .Y_W(Y_W), .D_W(D_W), .DEPTH(DEPTH),
    .STARVE_TH(STARVE_TH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pe_x(pe_x), .pe_y(pe_y), .pe_d(pe_d), .pe_v(pe_v), .pe_rdy(pe_rdy),
    .i_x(i_x), .i_y(i_y), .i_d(i_d), .i_v(i_v), .i_ack(i_ack),
    .count(count), .starve(starve), .stall_cnt(stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: packet queue, head wait length, PE stall count.
  logic [c_E_W-1:0] mq [$];
  int m_wait  = 0;
  int m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check current outputs, then drive one cycle of inputs and advance the model.
  task automatic cyc(input logic v, input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                     input logic [D_W-1:0] d, input logic ack, input logic rn);
    logic [c_E_W-1:0] h;
    logic e_rdy, e_v;
    @(negedge clk);
    e_rdy = (mq.size() < DEPTH);
    e_v   = (mq.size() > 0);
    h     = e_v ? mq[0] : '0;
    chk("pe_rdy",    pe_rdy,    e_rdy);
    chk("i_v",       i_v,       e_v);
    chk("i_x",       i_x,       h[c_E_W-1 -: X_W]);
    chk("i_y",       i_y,       h[D_W +: Y_W]);
    chk("i_d",       i_d,       h[D_W-1:0]);
    chk("count",     count,     64'(mq.size()));
    chk("starve",    starve,    (m_wait >= STARVE_TH));
    chk("stall_cnt", stall_cnt, 64'(m_stall));
    pe_v  = v;
    pe_x  = x;
    pe_y  = y;
    pe_d  = d;
    i_ack = ack;
    rst_n = rn;
    if (!rn) begin
      mq.delete();
      m_wait  = 0;
      m_stall = 0;
    end else begin
      if (v && !e_rdy && m_stall < (2**CNT_W - 1)) m_stall++;
      if (e_v && !ack) m_wait = (m_wait < STARVE_TH) ? m_wait + 1 : STARVE_TH;
      else             m_wait = 0;
      if (e_v && ack) void'(mq.pop_front());
      if (v && e_rdy) mq.push_back({x, y, d});
    end
  endtask

  task automatic idle(input logic ack);
    cyc(1'b0, '0, '0, '0, ack, 1'b1);
  endtask

  task automatic rand_phase(input int n, input int pv, input int pa, input int prst);
    for (int i = 0; i < n; i++) begin
      cyc(($urandom_range(0, 99) < pv),
          X_W'($urandom), Y_W'($urandom), D_W'($urandom),
          ($urandom_range(0, 99) < pa),
          !($urandom_range(0, 999) < prst));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pe_v  = 1'b0;
    pe_x  = '0;
    pe_y  = '0;
    pe_d  = '0;
    i_ack = 1'b0;
    repeat (2) @(posedge clk);

    // Single packet in, presented next cycle, then retired.
    cyc(1'b1, 2'd1, 2'd2, 32'hA5, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill past DEPTH with backpressure, then release one slot and drain.
    for (int i = 1; i <= 5; i++) cyc(1'b1, '0, '0, D_W'(i), 1'b0, 1'b1);
    repeat (3) cyc(1'b1, '0, '0, 32'd5, 1'b0, 1'b1);
    cyc(1'b1, '0, '0, 32'd5, 1'b1, 1'b1);
    cyc(1'b1, '0, '0, 32'd5, 1'b0, 1'b1);
    repeat (7) idle(1'b1);

    // Streaming with the router always accepting.
    for (int i = 0; i < 10; i++) cyc(1'b1, X_W'(i), Y_W'(i + 1), D_W'(32'h100 + i), 1'b1, 1'b1);
    repeat (2) idle(1'b1);

    // Head starvation and recovery.
    cyc(1'b1, 2'd3, 2'd3, 32'hBEEF, 1'b0, 1'b1);
    repeat (10) idle(1'b0);
    idle(1'b1);
    repeat (2) idle(1'b0);

    // Mid-operation reset discards queued packets.
    for (int i = 0; i < 3; i++) cyc(1'b1, '0, '0, D_W'(32'h200 + i), 1'b0, 1'b1);
    cyc(1'b1, '0, '0, 32'h2FF, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 2'd1, 32'h300, 1'b0, 1'b1);
    repeat (2) idle(1'b1);

    // Ack while empty is ignored.
    repeat (5) idle(1'b1);
    cyc(1'b1, 2'd1, 2'd1, 32'h400, 1'b1, 1'b1);
    repeat (2) idle(1'b1);

    // Randomized traffic across several load mixes.
    rand_phase(300, 90, 10, 0);
    rand_phase(300, 90, 95, 0);
    rand_phase(300, 40, 60, 0);
    rand_phase(200, 100, 0, 0);
    rand_phase(200, 10, 100, 0);
    rand_phase(400, 70, 50, 10);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_inject_queue.md
Name: pe_inject_queue

Overview:
- Injection buffer between a processing element (PE) and the PE port of the local DOR/backpressure router.
- Accepts packets from the PE with a valid/ready handshake and stores them in a first-word-fall-through FIFO.
- Presents the head packet to the router as i_x/i_y/i_d/i_v and retires it when the router returns i_ack.
- Tracks head-of-line waiting time and PE-side stalls, so software and the verification bench can observe router backpressure.

Parameters:
- X_W, 2, X address width; matches the router.
- Y_W, 2, Y address width; matches the router.
- D_W, 32, payload width.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- STARVE_TH, 8, consecutive head-wait cycles that assert starve.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- pe_x  input  X_W  destination X from the PE.
- pe_y  input  Y_W  destination Y from the PE.
- pe_d  input  D_W  payload from the PE.
- pe_v  input  1  PE packet valid.
- pe_rdy  output  1  queue can accept a packet this cycle.
- i_x  output  X_W  head destination X, to the router.
- i_y  output  Y_W  head destination Y, to the router.
- i_d  output  D_W  head payload, to the router.
- i_v  output  1  head valid, to the router.
- i_ack  input  1  router accepted the head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.
- starve  output  1  head has waited at least STARVE_TH cycles.
- stall_cnt  output  CNT_W  saturating count of cycles with pe_v=1 and pe_rdy=0.

Behaviour:
- Reset (rst_n=0 at a clock edge) sets:
  - pointers and count = 0, so i_v=0;
  - pe_rdy = 1;
  - i_x, i_y, i_d = 0;
  - starve = 0, wait counter = 0, stall_cnt = 0.
- Reset asserted mid-operation discards all stored packets; nothing is retired or presented afterwards.
- Push: occurs when pe_v && pe_rdy. Data is written at the tail, and the tail pointer wraps modulo DEPTH.
- pe_rdy = (count != DEPTH). It depends only on registered state; there is no combinational path from i_ack to pe_rdy.
  - When full, a push is refused even if a pop happens in the same cycle.
- Pop: occurs when i_v && i_ack. The head pointer wraps modulo DEPTH.
  - i_ack with i_v=0 is ignored.
- Head presentation:
  - i_v = (count != 0).
  - i_x/i_y/i_d come from the head entry and read as 0 when empty.
  - Latency: a packet pushed in cycle t appears on i_v no earlier than t+1. There is no combinational bypass.
- Simultaneous push and pop (count strictly between 0 and DEPTH): count is unchanged and both pointers advance.
- Ordering: strict FIFO; the head is stable while i_v=1 and i_ack=0.
- The router may de-assert i_ack for any number of cycles; the head must hold.
- Wait counter:
  - increments each cycle i_v=1 && i_ack=0, saturating at STARVE_TH;
  - clears on pop or when empty.
  - starve is registered and equals (wait counter == STARVE_TH).
- stall_cnt increments each cycle pe_v=1 && pe_rdy=0, saturating at 2^CNT_W-1; it is cleared only by reset.
- Destination fields are not interpreted. A packet addressed to the local node is forwarded to the router like any other.

Test Plan:
- Reset, then push (x=1, y=2, d=0xA5) in cycle 0 with i_ack=0 → i_v=1 from cycle 1 with i_x=1, i_y=2, i_d=0xA5, count=1. Then i_ack=1 for one cycle → count=0, i_v=0, i_x/i_y/i_d=0.
- DEPTH=4, i_ack=0, push d=1..5 on consecutive cycles → first four accepted, pe_rdy=0 at count=4, d=5 held and stall_cnt increments each held cycle. Then ack d=1 → pe_rdy=1 next cycle, d=5 accepted, and drain order is 1, 2, 3, 4, 5.
- i_ack held at 1 with continuous pushes → one packet per cycle in order; count stays 1; starve never asserts.
- Head held with i_ack=0 for 10 cycles (STARVE_TH=8) → starve rises after the 8th wait cycle and stays high. On ack, starve=0 the next cycle.
- Fill to 3 entries, assert rst_n=0 for one cycle → count=0, i_v=0, stall_cnt=0, pe_rdy=1. The next push is the only packet presented.
- i_ack=1 while empty for 5 cycles → no pointer change, count=0, no underflow. The next push is presented correctly.
